// File: rtl/access_control_mu_pkg.sv
// access_pkg: shared types and codes for the multi-user access controller.
//   state_e  - controller FSM states
//   REQ_*    - request codes on the req port
//   ST_*     - codes driven on the status port
//   clog2_min1 - ceil(log2(n)) with a floor of 1, for counter/index widths
package access_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_CHECK,
        S_DENIED,
        S_GRANTED,
        S_NEW_PW,
        S_LOCKED
    } state_e;

    localparam logic [1:0] REQ_NONE   = 2'b00;
    localparam logic [1:0] REQ_LOGIN  = 2'b01;
    localparam logic [1:0] REQ_CHANGE = 2'b10;
    localparam logic [1:0] REQ_LOGOUT = 2'b11;

    localparam logic [2:0] ST_IDLE       = 3'b000;
    localparam logic [2:0] ST_COLLECT    = 3'b001;
    localparam logic [2:0] ST_GRANTED    = 3'b010;
    localparam logic [2:0] ST_DENIED     = 3'b011;
    localparam logic [2:0] ST_LOCKED     = 3'b100;
    localparam logic [2:0] ST_PW_CHANGED = 3'b101;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/access_control_mu_pw_store.sv
// pw_store: NUM_USERS x PW_W password register file.
//   clk_i, rst_i - clock, synchronous active-high reset (all slots -> DEFAULT_PW)
//   we_i         - one-cycle write strobe
//   waddr_i      - slot written when we_i is high
//   wdata_i      - new password
//   raddr_i      - slot read combinationally onto rdata_o
module pw_store #(
    parameter int unsigned NUM_USERS  = 4,
    parameter int unsigned UID_W      = 2,
    parameter int unsigned PW_W       = 16,
    parameter logic [PW_W-1:0] DEFAULT_PW = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [UID_W-1:0] waddr_i,
    input  logic [PW_W-1:0]  wdata_i,
    input  logic [UID_W-1:0] raddr_i,
    output logic [PW_W-1:0]  rdata_o
);

    logic [PW_W-1:0] slots_q [NUM_USERS];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NUM_USERS; i++) begin
                slots_q[i] <= DEFAULT_PW;
            end
        end else if (we_i) begin
            slots_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = slots_q[raddr_i];

endmodule

// File: rtl/access_control_mu.sv
// access_control_mu: multi-user password access controller.
//   clk, rst     - clock, synchronous active-high reset
//   req          - 00 none, 01 login, 10 change pw, 11 logout
//   user_id      - slot selected by a login request
//   data_in      - entered digit, valid when data_load is high
//   data_load    - one-cycle digit strobe
//   access_grant - a user is logged in (GRANTED / NEW_PW)
//   locked       - lockout in progress
//   busy         - digits being collected or checked
//   status       - 000 idle, 001 collect, 010 granted, 011 denied, 100 locked, 101 pw changed
//   fail_count   - consecutive failed logins, clipped to 2 bits
module access_control_mu
    import access_pkg::*;
#(
    parameter int unsigned DIGIT_W     = 4,
    parameter int unsigned PW_LEN      = 4,
    parameter int unsigned NUM_USERS   = 4,
    parameter int unsigned MAX_FAILS   = 3,
    parameter int unsigned LOCK_CYCLES = 1024,
    parameter logic [DIGIT_W*PW_LEN-1:0] DEFAULT_PW = 16'h1234,
    localparam int unsigned PW_W  = DIGIT_W * PW_LEN,
    localparam int unsigned UID_W = clog2_min1(NUM_USERS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req,
    input  logic [UID_W-1:0]   user_id,
    input  logic [DIGIT_W-1:0] data_in,
    input  logic               data_load,
    output logic               access_grant,
    output logic               locked,
    output logic               busy,
    output logic [2:0]         status,
    output logic [1:0]         fail_count
);

    localparam int unsigned CW = $clog2(PW_LEN + 1);
    localparam int unsigned FW = $clog2(MAX_FAILS + 1);
    localparam int unsigned LW = clog2_min1(LOCK_CYCLES);

    state_e            state_q, state_d;
    logic [UID_W-1:0]  uid_q, uid_d;
    logic [PW_W-1:0]   digits_q, digits_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [FW-1:0]     fail_q, fail_d;
    logic [LW-1:0]     lock_q, lock_d;

    logic              we;
    logic [PW_W-1:0]   stored_pw;
    logic [PW_W-1:0]   digits_shifted;
    logic [FW-1:0]     fail_inc;
    logic              uid_ok;
    logic              last_load;
    logic              pw_done;

    pw_store #(
        .NUM_USERS  (NUM_USERS),
        .UID_W      (UID_W),
        .PW_W       (PW_W),
        .DEFAULT_PW (DEFAULT_PW)
    ) u_store (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (we),
        .waddr_i (uid_q),
        .wdata_i (digits_q),
        .raddr_i (uid_q),
        .rdata_o (stored_pw)
    );

    // First digit entered ends up as the most significant digit.
    assign digits_shifted = (digits_q << DIGIT_W) | PW_W'(data_in);
    assign fail_inc       = fail_q + FW'(1);
    assign uid_ok         = ({1'b0, user_id} < (UID_W + 1)'(NUM_USERS));
    assign last_load      = data_load && (cnt_q == CW'(PW_LEN - 1));
    // In NEW_PW the full password is held one extra cycle so the write
    // lands on the edge after the last load.
    assign pw_done        = (cnt_q == CW'(PW_LEN));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            uid_q    <= '0;
            digits_q <= '0;
            cnt_q    <= '0;
            fail_q   <= '0;
            lock_q   <= '0;
        end else begin
            state_q  <= state_d;
            uid_q    <= uid_d;
            digits_q <= digits_d;
            cnt_q    <= cnt_d;
            fail_q   <= fail_d;
            lock_q   <= lock_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        uid_d    = uid_q;
        digits_d = digits_q;
        cnt_d    = cnt_q;
        fail_d   = fail_q;
        lock_d   = lock_q;
        we       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req == REQ_LOGIN && uid_ok) begin
                    uid_d    = user_id;
                    digits_d = '0;
                    cnt_d    = '0;
                    state_d  = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (req == REQ_LOGOUT) begin
                    state_d = S_IDLE;
                end else if (data_load) begin
                    digits_d = digits_shifted;
                    cnt_d    = cnt_q + CW'(1);
                    if (last_load) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (digits_q == stored_pw) begin
                    fail_d  = '0;
                    state_d = S_GRANTED;
                end else begin
                    fail_d = fail_inc;
                    if (fail_inc == FW'(MAX_FAILS)) begin
                        lock_d  = LW'(LOCK_CYCLES - 1);
                        state_d = S_LOCKED;
                    end else begin
                        state_d = S_DENIED;
                    end
                end
            end
            S_DENIED: begin
                state_d = S_IDLE;
            end
            S_GRANTED: begin
                if (req == REQ_LOGOUT) begin
                    state_d = S_IDLE;
                end else if (req == REQ_CHANGE) begin
                    digits_d = '0;
                    cnt_d    = '0;
                    state_d  = S_NEW_PW;
                end
            end
            S_NEW_PW: begin
                if (pw_done) begin
                    we      = 1'b1;
                    state_d = S_GRANTED;
                end else if (req == REQ_LOGOUT) begin
                    state_d = S_IDLE;
                end else if (data_load) begin
                    digits_d = digits_shifted;
                    cnt_d    = cnt_q + CW'(1);
                end
            end
            S_LOCKED: begin
                if (lock_q == '0) begin
                    fail_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    lock_d = lock_q - LW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        access_grant = (state_q == S_GRANTED) || (state_q == S_NEW_PW);
        locked       = (state_q == S_LOCKED);
        busy         = (state_q == S_COLLECT) || (state_q == S_CHECK) || (state_q == S_NEW_PW);
        fail_count   = (32'(fail_q) > 32'd3) ? 2'd3 : 2'(fail_q);
        unique case (state_q)
            S_IDLE:    status = ST_IDLE;
            S_COLLECT: status = ST_COLLECT;
            S_CHECK:   status = ST_COLLECT;
            S_DENIED:  status = ST_DENIED;
            S_GRANTED: status = ST_GRANTED;
            S_NEW_PW:  status = pw_done ? ST_PW_CHANGED : ST_COLLECT;
            S_LOCKED:  status = ST_LOCKED;
            default:   status = ST_IDLE;
        endcase
    end

endmodule
